imem_loadable: RTL and testbench

Parametrised, run-time loadable instruction memory for the single-cycle LEGv8 core. It replaces a hard-coded program ROM with a RAM-backed store.
- After reset it zero-fills itself.
- It accepts a program image over a streaming valid/ready port.
- It serves combinational instruction fetch only while `ready` is high; the core stalls on `ready` low.

---
 rtl/imem_loadable.sv | 140 ++++++++++++++
 tb/tb_imem_loadable.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory for the single-cycle
// LEGv8 core. After reset it zero-fills every word. It then accepts a program
// image over a valid/ready stream. It serves combinational fetches only while
// `ready` is high.
//
// Ports:
//   clk, reset           - single clock; synchronous active-high reset
//   addr / q             - fetch word address / instruction (0 unless ready)
//   ready                - fetch data valid (IDLE only)
//   load_start, load_len - start a load of load_len words at word 0 (IDLE only;
//                          load_len must be 1..DEPTH or the request is dropped)
//   prog_valid/prog_data - program word stream
//   prog_ready           - a word is accepted this cycle (LOAD only)
//   load_busy            - high while clearing or loading
//   load_done            - one-cycle pulse on the first IDLE cycle after a load
module imem_loadable #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  ready,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_ready,
  output logic                  load_busy,
  output logic                  load_done
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  // DEPTH expressed in the width of load_len, for the range check.
  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] len_m1_q, len_m1_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  len_ok;
  logic [ADDR_WIDTH-1:0] len_m1_in;

  assign len_ok    = (load_len != '0) && (load_len <= DEPTH_LEN);
  assign len_m1_in = ADDR_WIDTH'(load_len - (ADDR_WIDTH + 1)'(1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_m1_d   = len_m1_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = prog_data;
    ready      = 1'b0;
    prog_ready = 1'b0;
    load_busy  = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        load_busy = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = '0;
        if (ptr_q == '1) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end

      S_IDLE: begin
        ready = 1'b1;
        if (load_start && len_ok) begin
          state_d  = S_LOAD;
          ptr_d    = '0;
          len_m1_d = len_m1_in;
        end
      end

      S_LOAD: begin
        prog_ready = 1'b1;
        load_busy  = 1'b1;
        if (prog_valid) begin
          mem_we = 1'b1;
          // Completion is judged against len_m1 so a full-depth load ends at
          // ptr == DEPTH-1 without wrapping back to word 0.
          if (ptr_q == len_m1_q) begin
            state_d = S_IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_CLEAR;
      ptr_q    <= '0;
      len_m1_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_m1_q <= len_m1_d;
      done_q   <= done_d;
    end
  end

  // Storage has no reset; CLEAR writes every word before the first fetch.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  assign q         = ready ? mem_q[addr] : '0;
  assign load_done = done_q;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr;
  logic [31:0] q;
  logic        ready;
  logic        load_start;
  logic [6:0]  load_len;
  logic        prog_valid;
  logic [31:0] prog_data;
  logic        prog_ready;
  logic        load_busy;
  logic        load_done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] img [64];

  typedef struct {
    int          phase;
    logic [5:0]  a;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[$];

  imem_loadable #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .q         (q),
    .ready     (ready),
    .load_start(load_start),
    .load_len  (load_len),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_ready(prog_ready),
    .load_busy (load_busy),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Entered on the negedge right after reset has been released.
  task automatic clear_seq(input string name);
    int bad, dones, zbad;
    bad = 0; dones = 0; zbad = 0;
    prog_valid = 1'b1;
    prog_data  = 32'h0000_0055;
    for (int c = 1; c <= 64; c++) begin
      load_start = (c >= 10 && c <= 12);
      load_len   = 7'd3;
      #1;
      if (ready !== 1'b0 || load_busy !== 1'b1 || prog_ready !== 1'b0 || q !== 32'h0) bad++;
      if (load_done !== 1'b0) dones++;
      @(negedge clk);
    end
    load_start = 1'b0;
    prog_valid = 1'b0;
    #1;
    check({name, " clear-phase outputs"}, 32'(bad), 32'd0);
    check({name, " no done during clear"}, 32'(dones), 32'd0);
    check({name, " ready on cycle 65"}, 32'(ready), 32'd1);
    check({name, " busy low on cycle 65"}, 32'(load_busy), 32'd0);
    check({name, " no done on cycle 65"}, 32'(load_done), 32'd0);
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      addr = 6'(a);
      #1;
      if (q !== 32'h0 || ready !== 1'b1 || load_done !== 1'b0) zbad++;
    end
    check({name, " all words zero"}, 32'(zbad), 32'd0);
  endtask

  // Starts a load in the current cycle; returns in the first IDLE cycle after.
  task automatic run_load(input string name, input logic [6:0] len, input bit gappy,
                          input int exp_cycles);
    int idx, cyc, bad;
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
    load_len   = 7'd0;
    idx = 0; cyc = 0; bad = 0;
    while (ready !== 1'b1 && cyc < 300) begin
      prog_valid = gappy ? (cyc % 2 == 1) : 1'b1;
      prog_data  = prog_valid ? img[idx] : 32'hdead_beef;
      #1;
      if (prog_ready !== 1'b1 || load_busy !== 1'b1 || q !== 32'h0 || load_done !== 1'b0) bad++;
      if (prog_valid && prog_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    prog_valid = 1'b0;
    prog_data  = 32'h0;
    #1;
    check({name, " load cycles"}, 32'(cyc), 32'(exp_cycles));
    check({name, " words accepted"}, 32'(idx), 32'(len));
    check({name, " LOAD-phase outputs"}, 32'(bad), 32'd0);
    check({name, " done pulse"}, 32'(load_done), 32'd1);
    check({name, " ready after load"}, 32'(ready), 32'd1);
    check({name, " busy after load"}, 32'(load_busy), 32'd0);
  endtask

  task automatic done_drops(input string name);
    @(negedge clk);
    #1;
    check({name, " done is one cycle"}, 32'(load_done), 32'd0);
  endtask

  task automatic apply_reads(input int phase);
    foreach (vecs[i]) begin
      if (vecs[i].phase == phase) begin
        @(negedge clk);
        addr = vecs[i].a;
        #1;
        check($sformatf("read p%0d addr %0d", phase, vecs[i].a), q, vecs[i].exp);
      end
    end
  endtask

  initial begin
    int bad_len [3];
    vecs.push_back('{1, 6'd0,  32'hf800_0000});
    vecs.push_back('{1, 6'd1,  32'hcb0e_01ce});
    vecs.push_back('{1, 6'd2,  32'hb400_004e});
    vecs.push_back('{1, 6'd3,  32'h0000_0000});
    vecs.push_back('{2, 6'd0,  32'h1234_5678});
    vecs.push_back('{2, 6'd1,  32'hcb0e_01ce});
    vecs.push_back('{2, 6'd2,  32'hb400_004e});
    vecs.push_back('{2, 6'd3,  32'h0000_0000});
    vecs.push_back('{2, 6'd63, 32'h0000_0000});
    vecs.push_back('{3, 6'd0,  32'd0});
    vecs.push_back('{3, 6'd1,  32'd1});
    vecs.push_back('{3, 6'd32, 32'd32});
    vecs.push_back('{3, 6'd62, 32'd62});
    vecs.push_back('{3, 6'd63, 32'd63});
    bad_len[0] = 0; bad_len[1] = 65; bad_len[2] = 96;

    reset = 1'b1; addr = 6'd0; load_start = 1'b0; load_len = 7'd0;
    prog_valid = 1'b0; prog_data = 32'h0;

    // Test 1: one-cycle reset pulse, clear sweep, zero readback.
    @(negedge clk);
    reset = 1'b0;
    clear_seq("T1");

    // Test 2: three-word load, streamed every cycle.
    img[0] = 32'hf800_0000; img[1] = 32'hcb0e_01ce; img[2] = 32'hb400_004e;
    addr = 6'd1;
    @(negedge clk);
    run_load("T2", 7'd3, 1'b0, 3);
    done_drops("T2");
    apply_reads(1);

    // Test 3: same load with idle cycles, then a back-to-back 1-word load
    // started in the load_done cycle.
    addr = 6'd1;
    @(negedge clk);
    run_load("T3", 7'd3, 1'b1, 6);
    img[0] = 32'h1234_5678;
    run_load("T3b", 7'd1, 1'b0, 1);
    done_drops("T3b");
    apply_reads(2);

    // Test 4: out-of-range lengths are dropped; prog_valid ignored in IDLE.
    foreach (bad_len[k]) begin
      @(negedge clk);
      addr       = 6'd0;
      load_start = 1'b1;
      load_len   = 7'(bad_len[k]);
      prog_valid = 1'b1;
      prog_data  = 32'hffff_ffff;
      #1;
      check($sformatf("T4 len %0d prog_ready", bad_len[k]), 32'(prog_ready), 32'd0);
      @(negedge clk);
      load_start = 1'b0;
      prog_valid = 1'b0;
      #1;
      check($sformatf("T4 len %0d ready", bad_len[k]), 32'(ready), 32'd1);
      check($sformatf("T4 len %0d busy", bad_len[k]), 32'(load_busy), 32'd0);
      check($sformatf("T4 len %0d no done", bad_len[k]), 32'(load_done), 32'd0);
    end
    apply_reads(2);

    // Test 5: full-depth load, value i at address i.
    for (int i = 0; i < 64; i++) img[i] = 32'(i);
    addr = 6'd1;
    @(negedge clk);
    run_load("T5", 7'd64, 1'b0, 64);
    done_drops("T5");
    apply_reads(3);

    // Test 6: reset after two of five words.
    for (int i = 0; i < 64; i++) img[i] = 32'(100 + i);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 7'd5;
    @(negedge clk);
    load_start = 1'b0;
    load_len   = 7'd0;
    prog_valid = 1'b1;
    prog_data  = img[0];
    @(negedge clk);
    prog_data  = img[1];
    @(negedge clk);
    prog_data  = img[2];
    reset      = 1'b1;
    #1;
    check("T6 still loading at reset", 32'(load_busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    clear_seq("T6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
